// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-register definitions.
// State encodings are reused by every pipeline stage register.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  function automatic logic st_has_main(
    input skid_state_e s
  );
    return s != ST_EMPTY;
  endfunction

  function automatic logic st_can_take(
    input skid_state_e s
  );
    return s != ST_SKID;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !at_max)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with freeze, flush and a stall counter.
// Ready/valid are decoded from state only, so no comb path crosses the stage.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH  = 128,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BUSYWAIT,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] STALL_COUNT
);

  skid_state_e      state_q;
  skid_state_e      state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;

  logic in_fire;
  logic out_fire;
  logic stall_en;

  assign IN_READY  = st_can_take(state_q);
  assign OUT_VALID = st_has_main(state_q);
  assign OUT_DATA  = main_q;

  assign in_fire  = IN_VALID & IN_READY & ~BUSYWAIT;
  assign out_fire = OUT_VALID & OUT_READY & ~BUSYWAIT;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else if (!BUSYWAIT) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = IN_DATA;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = IN_DATA;
          end else if (in_fire) begin
            skid_d  = IN_DATA;
            state_d = ST_SKID;
          end else if (out_fire) begin
            main_d  = BUBBLE;
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Back-pressured cycles only; freeze and flush cycles are not stalls.
  assign stall_en = OUT_VALID & ~OUT_READY & ~BUSYWAIT & ~FLUSH;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i(CLK),
    .clr_i(RESET),
    .en_i (stall_en),
    .cnt_o(STALL_COUNT)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, stream, skid, freeze, flush,
// mid-transfer reset and counter saturation on a narrow-counter instance.
module tb_pipe_skid_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic         busy;
  logic         flush;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  stall;

  logic [7:0]   b_in_data;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [7:0]   b_out_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [3:0]   b_stall;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .CLK        (clk),
    .RESET      (rst),
    .BUSYWAIT   (busy),
    .FLUSH      (flush),
    .IN_DATA    (in_data),
    .IN_VALID   (in_valid),
    .IN_READY   (in_ready),
    .OUT_DATA   (out_data),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .STALL_COUNT(stall)
  );

  pipe_skid_reg #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut_b (
    .CLK        (clk),
    .RESET      (rst),
    .BUSYWAIT   (1'b0),
    .FLUSH      (1'b0),
    .IN_DATA    (b_in_data),
    .IN_VALID   (b_in_valid),
    .IN_READY   (b_in_ready),
    .OUT_DATA   (b_out_data),
    .OUT_VALID  (b_out_valid),
    .OUT_READY  (b_out_ready),
    .STALL_COUNT(b_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; busy = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_data = 128'h5; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'h0; b_out_ready = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ready", in_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_b_stall", b_stall, 0);

    // streaming 1,2,3
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 128'h1; step();
    check("str1_data", out_data, 1);
    check("str1_valid", out_valid, 1);
    check("str1_ready", in_ready, 1);
    in_data = 128'h2; step();
    check("str2_data", out_data, 2);
    check("str2_ready", in_ready, 1);
    in_data = 128'h3; step();
    check("str3_data", out_data, 3);
    check("str3_ready", in_ready, 1);
    in_valid = 1'b0; step();
    check("str_drain_valid", out_valid, 0);
    check("str_drain_data", out_data, 0);
    check("str_stall", stall, 0);

    // back-pressure into skid
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 128'hA; step();
    check("bp_a_data", out_data, 128'hA);
    check("bp_a_stall", stall, 0);
    in_data = 128'hB; step();
    check("bp_skid_ready", in_ready, 0);
    check("bp_skid_data", out_data, 128'hA);
    check("bp_skid_stall", stall, 1);
    in_valid = 1'b0; step();
    check("bp_hold_data", out_data, 128'hA);
    check("bp_hold_stall", stall, 2);
    out_ready = 1'b1; step();
    check("bp_b_data", out_data, 128'hB);
    check("bp_b_ready", in_ready, 1);
    step();
    check("bp_end_valid", out_valid, 0);
    check("bp_end_stall", stall, 2);

    // freeze with FULL holding 0x7
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h7; step();
    check("frz_load", out_data, 128'h7);
    busy = 1'b1; in_data = 128'h9; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_data", out_data, 128'h7);
      check("frz_stall", stall, 2);
    end
    busy = 1'b0; step();
    check("frz_accept9", out_data, 128'h9);
    in_valid = 1'b0; step();
    check("frz_drain", out_valid, 0);

    // flush from SKID with busywait and input
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 128'hA; step();
    in_data = 128'hB; step();
    check("fl_skid_ready", in_ready, 0);
    check("fl_pre_stall", stall, 3);
    flush = 1'b1; busy = 1'b1; in_data = 128'hC; step();
    check("fl_valid", out_valid, 0);
    check("fl_data", out_data, 0);
    check("fl_ready", in_ready, 1);
    check("fl_stall", stall, 3);
    flush = 1'b0; busy = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("fl_after_valid", out_valid, 0);
    check("fl_after_data", out_data, 0);

    // reset mid-transfer in SKID
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 128'hD; step();
    in_data = 128'hE; step();
    check("mr_skid_ready", in_ready, 0);
    rst = 1'b1; step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("mr_valid", out_valid, 0);
    check("mr_data", out_data, 0);
    check("mr_ready", in_ready, 1);
    check("mr_stall", stall, 0);
    step();
    check("mr_after_valid", out_valid, 0);

    // saturation on 4-bit counter
    b_in_valid = 1'b1; b_in_data = 8'h3C; b_out_ready = 1'b0;
    step();
    b_in_valid = 1'b0;
    check("sat_load", b_out_data, 8'h3C);
    check("sat_start", b_stall, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check("sat_cnt", b_stall, (i > 15) ? 15 : i);
    end
    check("sat_hold_data", b_out_data, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
